// File: rtl/serial_pkg.sv
// Shared definitions for the serial front-end family: state encoding used by
// both the serializer and the sequence detector, plus a counter-width helper.
package serial_pkg;

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT
  } ser_state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage. One word is buffered in a holding register
// while the previous word shifts out, so back-to-back words stream without gaps.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             x_out,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_reg_q, hold_reg_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             fs_q, fs_d;
  logic             fe_q, fe_d;
  logic             in_ready_q, in_ready_d;

  logic             in_fire;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_shifted;

  assign in_fire = in_valid && in_ready_q;

  // Output-end bit and the zero-filled shift toward the output end.
  always_comb begin
    if (MSB_FIRST) begin
      cur_bit       = shreg_q[WIDTH-1];
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      cur_bit       = shreg_q[0];
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: handshake into the holding register, load/shift/reload.
  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_reg_d  = hold_reg_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    x_out_d     = x_out_q;
    x_valid_d   = 1'b0;
    fs_d        = 1'b0;
    fe_d        = 1'b0;

    // in_ready is low whenever the holding register is full, so an accept
    // never collides with a load/reload that empties it on the same edge.
    if (in_fire) begin
      hold_reg_d  = in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shreg_d     = hold_reg_q;
          hold_full_d = 1'b0;
          bitcnt_d    = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ser_en) begin
          x_out_d   = cur_bit;
          x_valid_d = 1'b1;
          fs_d      = (bitcnt_q == '0);
          fe_d      = (bitcnt_q == LAST);
          shreg_d   = shreg_shifted;
          bitcnt_d  = bitcnt_q + CW'(1);
          if (bitcnt_q == LAST) begin
            bitcnt_d = '0;
            if (hold_full_q) begin
              // Reload straight from the holding register: no idle cycle.
              shreg_d     = hold_reg_q;
              hold_full_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = !hold_full_d;
  end

  // State and datapath registers; reset discards any partial or held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_reg_q  <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      x_out_q     <= 1'b0;
      x_valid_q   <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_reg_q  <= hold_reg_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign x_out       = x_out_q;
  assign x_valid     = x_valid_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign busy        = (state_q == ST_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two serializers (MSB-first and LSB-first) share one
// input stream; a queue-based bit model predicts every serial bit and marker.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         ser_en;

  logic in_ready_m, x_out_m, x_valid_m, fs_m, fe_m, busy_m;
  logic in_ready_l, x_out_l, x_valid_l, fs_l, fe_l, busy_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .ser_en(ser_en), .x_out(x_out_m),
    .x_valid(x_valid_m), .frame_start(fs_m), .frame_end(fe_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .ser_en(ser_en), .x_out(x_out_l),
    .x_valid(x_valid_l), .frame_start(fs_l), .frame_end(fe_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
  } xbit_t;

  xbit_t exp_m[$];
  xbit_t exp_l[$];

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   xv_cnt[2] = '{0, 0};
  logic last_x[2] = '{1'b0, 1'b0};
  logic en_prev = 1'b0;
  int   en_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: every accepted word becomes WIDTH expected bits in
  // transmit order; reset throws away whatever is still pending.
  always @(posedge clk) begin
    cyc++;
    en_prev = ser_en;
    if (reset) begin
      exp_m.delete();
      exp_l.delete();
      last_x[0] = 1'b0;
      last_x[1] = 1'b0;
    end else if (in_valid && in_ready_m) begin
      for (int i = 0; i < W; i++) begin
        exp_m.push_back('{b: in_data[W-1-i], fs: (i == 0), fe: (i == W-1)});
        exp_l.push_back('{b: in_data[i],     fs: (i == 0), fe: (i == W-1)});
      end
    end
  end

  task automatic mon(input int k, input logic xv, input logic xo,
                     input logic fs, input logic fe);
    xbit_t e;
    logic  have;
    have = 1'b0;
    if (xv) begin
      chk("xv_needs_en", en_prev, 1);
      if (k == 0 && exp_m.size() > 0) begin e = exp_m.pop_front(); have = 1'b1; end
      if (k == 1 && exp_l.size() > 0) begin e = exp_l.pop_front(); have = 1'b1; end
      if (!have) chk("xv_extra", xv, 0);
      else begin
        chk(k == 0 ? "bit_msb" : "bit_lsb", xo, e.b);
        chk(k == 0 ? "fs_msb" : "fs_lsb", fs, e.fs);
        chk(k == 0 ? "fe_msb" : "fe_lsb", fe, e.fe);
      end
      last_x[k] = xo;
      xv_cnt[k]++;
    end else begin
      chk("x_hold", xo, last_x[k]);
      chk("fs_idle", fs, 0);
      chk("fe_idle", fe, 0);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      mon(0, x_valid_m, x_out_m, fs_m, fe_m);
      mon(1, x_valid_l, x_out_l, fs_l, fe_l);
      chk("ready_match", in_ready_l, in_ready_m);
    end
  end

  // Bit-rate enable generator.
  initial begin
    int en_cnt;
    en_cnt = 0;
    ser_en = 1'b1;
    forever begin
      @(negedge clk);
      case (en_mode)
        0: ser_en = 1'b1;
        1: begin
          ser_en = (en_cnt == 0);
          en_cnt = (en_cnt == 2) ? 0 : en_cnt + 1;
        end
        default: ser_en = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Present a word at a negedge and return at the negedge after it is taken.
  task automatic send_word(input logic [W-1:0] w);
    int t;
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready_m && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", (t < 200), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_m.size() != 0 || exp_l.size() != 0 || busy_m) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", (t < 400), 1);
    @(negedge clk);
    chk("drain_busy", busy_m, 0);
    chk("drain_ready", in_ready_m, 1);
  endtask

  task automatic wait_xv(input string tag);
    int t;
    t = 0;
    while (!x_valid_m && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (t < 100), 1);
  endtask

  initial begin
    int t;
    int base;
    int stamp[8];
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready_m, 1);
    chk("rst_busy", busy_m, 0);
    chk("rst_xv", x_valid_m, 0);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", in_ready_m, 1);
      chk("idle_busy", busy_m, 0);
      chk("idle_xv", x_valid_m, 0);
      chk("idle_xout", x_out_m, 0);
    end

    // Single word, latency and busy.
    send_word(8'b1101_0110);
    t = 0;
    while (!x_valid_m && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("latency", t, 2);
    chk("busy_shift", busy_m, 1);
    drain();

    // Back-to-back words: 16 gap-free bits.
    send_word(8'hA5);
    chk("ready_low_held", in_ready_m, 0);
    send_word(8'h3C);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("gapfree_xv", x_valid_m, 1);
    end
    drain();

    // Throttled enable: one pulse every third cycle.
    en_mode = 1;
    send_word(8'hF0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      wait_xv("throttle_timeout");
      stamp[i] = cyc;
    end
    for (int i = 1; i < 8; i++) chk("throttle_gap", stamp[i] - stamp[i-1], 3);
    en_mode = 0;
    drain();

    // LSB-first word 01.
    send_word(8'h01);
    wait_xv("lsb_timeout");
    chk("lsb_first_bit", x_out_l, 1);
    chk("lsb_first_fs", fs_l, 1);
    drain();

    // Reset mid-word with a word held.
    base = xv_cnt[0];
    send_word(8'hFF);
    send_word(8'h00);
    t = 0;
    while (xv_cnt[0] < base + 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("midword_timeout", (t < 50), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_xout", x_out_m, 0);
    chk("arst_xv", x_valid_m, 0);
    chk("arst_fs", fs_m, 0);
    chk("arst_fe", fe_m, 0);
    chk("arst_busy", busy_m, 0);
    chk("arst_ready", in_ready_m, 1);
    @(negedge clk);
    reset = 1'b0;
    base = xv_cnt[0];
    send_word(8'h80);
    wait_xv("post_rst_timeout");
    chk("post_rst_bit", x_out_m, 1);
    chk("post_rst_fs", fs_m, 1);
    drain();
    chk("post_rst_count", xv_cnt[0] - base, 8);

    // Random words, random enable, random producer gaps.
    en_mode = 2;
    for (int n = 0; n < 30; n++) begin
      send_word(W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    en_mode = 0;
    drain();
    chk("lsb_count_match", xv_cnt[1], xv_cnt[0]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
